// File: rtl/shift_seq_engine_pkg.sv
// Shared definitions for the multi-cycle shift/rotate engine: opcode encoding,
// FSM state encoding and the opcode legality check.
package shift_pkg;

    localparam logic [2:0] OP_SRA = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SLA = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Codes 110 and 111 are unassigned and reported as errors.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/shift_seq_engine_step.sv
// Single-position shift/rotate of a WIDTH-bit value; purely combinational.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = data;
        case (opcode)
            OP_SRA:  next = {data[WIDTH-1], data[WIDTH-1:1]};
            OP_SRL:  next = {1'b0, data[WIDTH-1:1]};
            OP_SLA:  next = {data[WIDTH-2:0], 1'b0};
            OP_SLL:  next = {data[WIDTH-2:0], 1'b0};
            OP_ROR:  next = {data[0], data[WIDTH-1:1]};
            OP_ROL:  next = {data[WIDTH-2:0], data[WIDTH-1]};
            default: next = data;
        endcase
    end

endmodule

// File: rtl/shift_seq_engine.sv
// Multi-cycle shift/rotate engine: accepts one request, applies one single-bit
// step per clock for `amount` clocks, then holds the result until consumed.
module shift_seq_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       opcode_i,
    input  logic [AMT_W-1:0] amount_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o,
    output logic             busy_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in HOLD and
    // result_o/err_o stay stable until out_ready is seen there.

    state_t           state;
    logic [2:0]       op;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_next;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data   (result_o),
        .opcode (op),
        .next   (step_next)
    );

    assign in_ready = (state == IDLE);
    assign busy_o   = (state == SHIFT) || (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_SRA;
            cnt       <= '0;
            result_o  <= '0;
            out_valid <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op  <= opcode_i;
                        cnt <= amount_i;
                        if (!is_legal_op(opcode_i)) begin
                            result_o  <= '0;
                            err_o     <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (amount_i == '0) begin
                            result_o  <= data_i;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            result_o <= data_i;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    result_o <= step_next;
                    cnt      <= cnt - AMT_W'(1);
                    // The step taken with one position left is the last one.
                    if (cnt == AMT_W'(1)) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        err_o     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    err_o     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_engine.sv
// Directed bench for shift_seq_engine: a table of requests with hand-computed
// results and latencies, plus backpressure and mid-operation reset sequences.
module tb_shift_seq_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_i;
    logic [2:0]       opcode_i;
    logic [AMT_W-1:0] amount_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic             err_o;
    logic             busy_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [2:0]       op;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] exp_result;
        logic             exp_err;
        int               exp_lat;
    } vec_t;

    vec_t vecs[10];

    shift_seq_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .opcode_i  (opcode_i),
        .amount_i  (amount_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a request at a negedge and hold it through the accepting edge,
    // then scramble the inputs so later sampling would be visible.
    task automatic send(input logic [WIDTH-1:0] d, input logic [2:0] op, input logic [AMT_W-1:0] amt);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1'b1);
        data_i   = d;
        opcode_i = op;
        amount_i = amt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_i   = ~d;
        opcode_i = 3'b111;
        amount_i = AMT_W'($urandom_range(0, WIDTH - 1));
    endtask

    // Count sampling negedges after the accept edge until out_valid shows.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_drain", out_valid, 1'b0);
        check("err_after_drain", err_o, 1'b0);
        check("in_ready_after_drain", in_ready, 1'b1);
        check("busy_after_drain", busy_o, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        send(v.data, v.op, v.amt);
        wait_out(lat);
        check("latency", lat, v.exp_lat);
        check("result", result_o, v.exp_result);
        check("err", err_o, v.exp_err);
        check("busy_in_hold", busy_o, 1'b1);
        check("in_ready_in_hold", in_ready, 1'b0);
        drain();
    endtask

    initial begin
        int lat;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_i    = '0;
        opcode_i  = '0;
        amount_i  = '0;

        vecs[0] = '{8'h96, 3'b000, 3'd3, 8'hF2, 1'b0, 4};
        vecs[1] = '{8'h81, 3'b101, 3'd7, 8'hC0, 1'b0, 8};
        vecs[2] = '{8'h81, 3'b100, 3'd1, 8'hC0, 1'b0, 2};
        vecs[3] = '{8'hFF, 3'b001, 3'd0, 8'hFF, 1'b0, 1};
        vecs[4] = '{8'hFF, 3'b001, 3'd7, 8'h01, 1'b0, 8};
        vecs[5] = '{8'h5A, 3'b110, 3'd4, 8'h00, 1'b1, 1};
        vecs[6] = '{8'h81, 3'b010, 3'd1, 8'h02, 1'b0, 2};
        vecs[7] = '{8'h80, 3'b000, 3'd7, 8'hFF, 1'b0, 8};
        vecs[8] = '{8'h01, 3'b100, 3'd3, 8'h20, 1'b0, 4};
        vecs[9] = '{8'hC3, 3'b111, 3'd0, 8'h00, 1'b1, 1};

        // Reset state
        #12;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result_o, 8'h00);
        check("reset_err", err_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held while out_ready is low, requests ignored
        send(8'h0F, 3'b011, 3'd2);
        wait_out(lat);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            data_i   = 8'hE7;
            opcode_i = 3'b001;
            amount_i = 3'd1;
            @(negedge clk);
            check("bp_result", result_o, 8'h3C);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        drain();
        run_vec('{8'h33, 3'b011, 3'd1, 8'h66, 1'b0, 2});

        // Asynchronous reset two steps into a SHIFT
        send(8'hAA, 3'b100, 3'd6);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_result", result_o, 8'h00);
        check("mid_reset_busy", busy_o, 1'b0);
        check("mid_reset_in_ready", in_ready, 1'b1);
        check("mid_reset_err", err_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{8'hAA, 3'b100, 3'd6, 8'hAA, 1'b0, 7});
        run_vec('{8'h96, 3'b000, 3'd3, 8'hF2, 1'b0, 4});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
